// File: rtl/conn_aging_scanner_pkg.sv
// conn_aging_scanner_pkg: scan FSM encoding and table-entry constants shared
// by the aging scanner and its touch guard.
package conn_aging_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_EMIT  = 3'd4
    } scan_state_e;

    // Entry 0 is reserved and never scanned.
    localparam int unsigned IDX_RSVD = 0;

    // Entry layout: {valid, timestamp}; the timestamp occupies the low bits.
    localparam int unsigned TS_LSB = 0;

endpackage

// File: rtl/aging_touch_guard.sv
// aging_touch_guard: remembers whether the lookup path refreshed the entry
// currently being examined, so a freshly touched entry is never aged out.
module aging_touch_guard #(
    parameter int unsigned D_AGINGTB = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 arm,
    input  logic                 touch_valid,
    input  logic [D_AGINGTB-1:0] touch_idx,
    input  logic [D_AGINGTB-1:0] idx,
    output logic                 hit
);
    logic hit_q;
    logic hit_d;
    logic match_s;

    // Index compare and sticky-flag next state; a touch in the current cycle counts immediately.
    always_comb begin
        match_s = arm && touch_valid && (touch_idx == idx);
        if (clr) begin
            hit_d = 1'b0;
        end else if (match_s) begin
            hit_d = 1'b1;
        end else begin
            hit_d = hit_q;
        end
    end

    // Hit flag register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit = hit_q || match_s;

endmodule

// File: rtl/conn_aging_scanner.sv
// conn_aging_scanner: sweeps the connection aging table, clears entries whose
// last-seen timestamp is older than the timeout latched at sweep start, and
// reports each aged index over a valid/ready handshake.
// Build option: define AGING_STATS_EN to add the saturating aged_cnt output.
module conn_aging_scanner
    import conn_aging_scanner_pkg::*;
#(
    parameter int unsigned D_AGINGTB   = 10,
    parameter int unsigned W_TS        = 16,
    parameter int unsigned W_AGINGTB   = W_TS + 1,
    parameter int unsigned RAM_LAT     = 2,
    parameter int unsigned W_AGINGINFO = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   scan_en,
    input  logic [W_TS-1:0]        timeout_cfg,
    input  logic [W_TS-1:0]        cur_timestamp,
    output logic [D_AGINGTB-1:0]   idx_agingTb,
    output logic                   rdValid_agingTb,
    output logic                   wrValid_agingTb,
    output logic [W_AGINGTB-1:0]   data_agingTb,
    input  logic [W_AGINGTB-1:0]   ctx_agingTb,
    input  logic                   touch_valid,
    input  logic [D_AGINGTB-1:0]   touch_idx,
    output logic                   agingInfo_valid,
    input  logic                   agingInfo_ready,
    output logic [W_AGINGINFO-1:0] agingInfo,
    output logic                   sweep_done
`ifdef AGING_STATS_EN
    ,
    output logic [31:0]            aged_cnt
`endif
);
    localparam int unsigned W_WC = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [D_AGINGTB-1:0] IDX_LAST   = {D_AGINGTB{1'b1}};
    localparam logic [D_AGINGTB-1:0] IDX_FIRST  = D_AGINGTB'(1);
    localparam logic [D_AGINGTB-1:0] IDX_RSVD_C = D_AGINGTB'(IDX_RSVD);
    localparam logic [W_WC-1:0]      WAIT_LAST  = W_WC'(RAM_LAT - 1);

    scan_state_e            state_q, state_d;
    logic [D_AGINGTB-1:0]   idx_q, idx_d;
    logic [W_TS-1:0]        timeout_q, timeout_d;
    logic [W_WC-1:0]        wait_cnt_q, wait_cnt_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   info_valid_q, info_valid_d;
    logic [W_AGINGINFO-1:0] info_q, info_d;

    logic                   entry_vld_s;
    logic [W_TS-1:0]        entry_ts_s;
    logic [W_TS-1:0]        age_s;
    logic                   hit_s;
    logic                   expired_s;
    logic                   arm_s;
    logic                   clr_s;
    logic                   wr_valid_s;
    logic                   sweep_done_s;

    assign entry_vld_s = ctx_agingTb[W_TS];
    assign entry_ts_s  = ctx_agingTb[TS_LSB +: W_TS];
    // Modular subtraction keeps the age correct across a timestamp wrap.
    assign age_s       = cur_timestamp - entry_ts_s;
    assign expired_s   = entry_vld_s && (timeout_q != {W_TS{1'b0}}) &&
                         (age_s >= timeout_q) && !hit_s;

    // Touches count from the read strobe until the entry has been checked.
    assign arm_s = (state_q == ST_RD) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign clr_s = (state_q == ST_IDLE);

    aging_touch_guard #(
        .D_AGINGTB (D_AGINGTB)
    ) u_touch_guard (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr_s),
        .arm         (arm_s),
        .touch_valid (touch_valid),
        .touch_idx   (touch_idx),
        .idx         (idx_q),
        .hit         (hit_s)
    );

    // Scan FSM next state, index stepping, timeout latch and event capture.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timeout_d    = timeout_q;
        wait_cnt_d   = wait_cnt_q;
        info_d       = info_q;
        wr_valid_s   = 1'b0;
        sweep_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scan_en) begin
                    if ((idx_q == IDX_LAST) || (idx_q == IDX_RSVD_C)) begin
                        idx_d     = IDX_FIRST;
                        timeout_d = timeout_cfg;
                    end else begin
                        idx_d = idx_q + IDX_FIRST;
                    end
                    state_d = ST_RD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                wait_cnt_d = W_WC'(1);
                if (RAM_LAT > 1) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q >= WAIT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + W_WC'(1);
                end
            end
            ST_CHECK: begin
                if (expired_s) begin
                    wr_valid_s = 1'b1;
                    info_d     = W_AGINGINFO'(idx_q);
                    state_d    = ST_EMIT;
                end else begin
                    sweep_done_s = (idx_q == IDX_LAST);
                    state_d      = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (agingInfo_ready) begin
                    info_d       = {W_AGINGINFO{1'b0}};
                    sweep_done_s = (idx_q == IDX_LAST);
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rd_valid_d   = (state_d == ST_RD);
        info_valid_d = (state_d == ST_EMIT);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= {D_AGINGTB{1'b0}};
            timeout_q    <= {W_TS{1'b0}};
            wait_cnt_q   <= {W_WC{1'b0}};
            rd_valid_q   <= 1'b0;
            info_valid_q <= 1'b0;
            info_q       <= {W_AGINGINFO{1'b0}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timeout_q    <= timeout_d;
            wait_cnt_q   <= wait_cnt_d;
            rd_valid_q   <= rd_valid_d;
            info_valid_q <= info_valid_d;
            info_q       <= info_d;
        end
    end

    assign idx_agingTb     = idx_q;
    assign rdValid_agingTb = rd_valid_q;
    // The clear and the end-of-sweep pulse belong to the check cycle itself; a reset suppresses both.
    assign wrValid_agingTb = wr_valid_s && reset;
    assign sweep_done      = sweep_done_s && reset;
    assign data_agingTb    = {W_AGINGTB{1'b0}};
    assign agingInfo_valid = info_valid_q;
    assign agingInfo       = info_q;

`ifdef AGING_STATS_EN
    logic [31:0] aged_cnt_q;

    // Saturating count of expiry writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            aged_cnt_q <= 32'd0;
        end else if (wrValid_agingTb && (aged_cnt_q != 32'hFFFF_FFFF)) begin
            aged_cnt_q <= aged_cnt_q + 32'd1;
        end else begin
            aged_cnt_q <= aged_cnt_q;
        end
    end

    assign aged_cnt = aged_cnt_q;
`endif

endmodule

// File: tb/tb_conn_aging_scanner.sv
// tb_conn_aging_scanner: directed bench for conn_aging_scanner with a table
// model (two-cycle read pipeline) and a small 3-bit-index instance for sweep order.
module tb_conn_aging_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        scan_en;
    logic [15:0] timeout_cfg;
    logic [15:0] cur_timestamp;
    logic [9:0]  idx_agingTb;
    logic        rdValid_agingTb;
    logic        wrValid_agingTb;
    logic [16:0] data_agingTb;
    logic [16:0] ctx_agingTb;
    logic        touch_valid;
    logic [9:0]  touch_idx;
    logic        agingInfo_valid;
    logic        agingInfo_ready;
    logic [15:0] agingInfo;
    logic        sweep_done;
`ifdef AGING_STATS_EN
    logic [31:0] aged_cnt;
    logic [31:0] s_aged_cnt;
`endif

    // small instance signals
    logic        s_scan_en;
    logic [2:0]  s_idx;
    logic        s_rd;
    logic        s_wr;
    logic [16:0] s_data;
    logic [16:0] s_ctx;
    logic [2:0]  s_touch_idx;
    logic        s_ev_valid;
    logic [15:0] s_info;
    logic        s_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [16:0] mem      [0:1023];
    logic [16:0] init_mem [0:1023];
    logic [16:0] pipe0, pipe1;
    int          rd_n, wr_n, ev_n;
    logic [9:0]  rd_log [0:63];
    logic [9:0]  wr_log [0:63];
    logic [15:0] ev_log [0:63];
    logic [16:0] wr_dor;

    int          s_rd_n, s_done_n, s_done_at;
    logic [2:0]  s_rd_log [0:15];
    logic [2:0]  s_done_idx;

    assign ctx_agingTb = pipe1;
    assign s_ctx       = 17'h0;
    assign s_touch_idx = 3'd0;

    always #5 clk = ~clk;

    conn_aging_scanner #(
        .D_AGINGTB(10), .W_TS(16), .W_AGINGTB(17), .RAM_LAT(2), .W_AGINGINFO(16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .scan_en         (scan_en),
        .timeout_cfg     (timeout_cfg),
        .cur_timestamp   (cur_timestamp),
        .idx_agingTb     (idx_agingTb),
        .rdValid_agingTb (rdValid_agingTb),
        .wrValid_agingTb (wrValid_agingTb),
        .data_agingTb    (data_agingTb),
        .ctx_agingTb     (ctx_agingTb),
        .touch_valid     (touch_valid),
        .touch_idx       (touch_idx),
        .agingInfo_valid (agingInfo_valid),
        .agingInfo_ready (agingInfo_ready),
        .agingInfo       (agingInfo),
        .sweep_done      (sweep_done)
`ifdef AGING_STATS_EN
        ,
        .aged_cnt        (aged_cnt)
`endif
    );

    conn_aging_scanner #(
        .D_AGINGTB(3), .W_TS(16), .W_AGINGTB(17), .RAM_LAT(2), .W_AGINGINFO(16)
    ) u_small (
        .clk             (clk),
        .reset           (reset),
        .scan_en         (s_scan_en),
        .timeout_cfg     (16'd100),
        .cur_timestamp   (16'd0),
        .idx_agingTb     (s_idx),
        .rdValid_agingTb (s_rd),
        .wrValid_agingTb (s_wr),
        .data_agingTb    (s_data),
        .ctx_agingTb     (s_ctx),
        .touch_valid     (1'b0),
        .touch_idx       (s_touch_idx),
        .agingInfo_valid (s_ev_valid),
        .agingInfo_ready (1'b1),
        .agingInfo       (s_info),
        .sweep_done      (s_done)
`ifdef AGING_STATS_EN
        ,
        .aged_cnt        (s_aged_cnt)
`endif
    );

    // Aging-table model (loaded from init_mem in reset) and activity logs of the main instance.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_mem[i];
            pipe0  <= 17'h0;
            pipe1  <= 17'h0;
            rd_n   <= 0;
            wr_n   <= 0;
            ev_n   <= 0;
            wr_dor <= 17'h0;
        end else begin
            pipe0 <= rdValid_agingTb ? mem[idx_agingTb] : 17'h0;
            pipe1 <= pipe0;
            if (rdValid_agingTb) begin
                if (rd_n < 64) rd_log[rd_n] <= idx_agingTb;
                rd_n <= rd_n + 1;
            end
            if (wrValid_agingTb) begin
                mem[idx_agingTb] <= data_agingTb;
                if (wr_n < 64) wr_log[wr_n] <= idx_agingTb;
                wr_n   <= wr_n + 1;
                wr_dor <= wr_dor | data_agingTb;
            end
            if (agingInfo_valid && agingInfo_ready) begin
                if (ev_n < 64) ev_log[ev_n] <= agingInfo;
                ev_n <= ev_n + 1;
            end
        end
    end

    // Read order and sweep_done position of the small instance.
    always @(posedge clk) begin
        if (!reset) begin
            s_rd_n     <= 0;
            s_done_n   <= 0;
            s_done_at  <= 0;
            s_done_idx <= 3'd0;
        end else begin
            if (s_rd) begin
                if (s_rd_n < 16) s_rd_log[s_rd_n] <= s_idx;
                s_rd_n <= s_rd_n + 1;
            end
            if (s_done) begin
                s_done_n   <= s_done_n + 1;
                s_done_at  <= s_rd_n;
                s_done_idx <= s_idx;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_init();
        for (int i = 0; i < 1024; i++) init_mem[i] = 17'h0;
    endtask

    task automatic wait_rd(input string tag, input logic [9:0] target, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rdValid_agingTb && (idx_agingTb == target)) begin
                found = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic wait_ev(input string tag, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (agingInfo_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        int held;
        int rd_bad;
        logic found;
        reset = 1'b0; scan_en = 1'b0; s_scan_en = 1'b0;
        timeout_cfg = 16'd0; cur_timestamp = 16'd0;
        touch_valid = 1'b0; touch_idx = 10'd0; agingInfo_ready = 1'b1;
        clear_init();

        // reset state
        do_reset();
        @(negedge clk);
        check_eq("rst_rdValid", {31'd0, rdValid_agingTb}, 32'd0);
        check_eq("rst_wrValid", {31'd0, wrValid_agingTb}, 32'd0);
        check_eq("rst_idx", {22'd0, idx_agingTb}, 32'd0);
        check_eq("rst_evValid", {31'd0, agingInfo_valid}, 32'd0);
        check_eq("rst_info", {16'd0, agingInfo}, 32'd0);
        check_eq("rst_done", {31'd0, sweep_done}, 32'd0);
        check_eq("rst_data", {15'd0, data_agingTb}, 32'd0);

        // basic expiry; timeout latched at sweep start
        clear_init();
        init_mem[5] = {1'b1, 16'd0};
        init_mem[6] = {1'b1, 16'd1};
        timeout_cfg = 16'd100; cur_timestamp = 16'd100;
        do_reset();
        scan_en = 1'b1;
        wait_rd("t1_start", 10'd1, 10);
        timeout_cfg = 16'd0;
        wait_rd("t1_reach8", 10'd8, 80);
        check_eq("t1_wr_n", wr_n, 32'd1);
        check_eq("t1_wr_idx", {22'd0, wr_log[0]}, 32'd5);
        check_eq("t1_wr_data", {15'd0, wr_dor}, 32'd0);
        check_eq("t1_ev_n", ev_n, 32'd1);
        check_eq("t1_ev_info", {16'd0, ev_log[0]}, 32'd5);
        check_eq("t1_mem5", {15'd0, mem[5]}, 32'd0);
        check_eq("t1_mem6", {15'd0, mem[6]}, 32'h0001_0001);
`ifdef AGING_STATS_EN
        check_eq("t1_aged_cnt", aged_cnt, 32'd1);
`endif
        scan_en = 1'b0;

        // aging off (timeout 0) and scan_en pause/resume
        clear_init();
        init_mem[5] = {1'b1, 16'd0};
        timeout_cfg = 16'd0; cur_timestamp = 16'd100;
        do_reset();
        scan_en = 1'b1;
        wait_rd("off_r3", 10'd3, 20);
        scan_en = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("off_hold_rd_n", rd_n, 32'd3);
        check_eq("off_hold_idx", {22'd0, idx_agingTb}, 32'd3);
        scan_en = 1'b1;
        wait_rd("off_resume4", 10'd4, 10);
        wait_rd("off_r8", 10'd8, 40);
        check_eq("off_wr_n", wr_n, 32'd0);
        check_eq("off_ev_n", ev_n, 32'd0);
        scan_en = 1'b0;

        // timestamp wrap: age 100 expires, age 99 does not
        clear_init();
        init_mem[7] = {1'b1, 16'hFFF0};
        init_mem[8] = {1'b1, 16'hFFF1};
        timeout_cfg = 16'd100; cur_timestamp = 16'h0054;
        do_reset();
        scan_en = 1'b1;
        wait_rd("t2_r9", 10'd9, 60);
        check_eq("t2_wr_n", wr_n, 32'd1);
        check_eq("t2_wr_idx", {22'd0, wr_log[0]}, 32'd7);
        check_eq("t2_ev_info", {16'd0, ev_log[0]}, 32'd7);
        check_eq("t2_mem8", {15'd0, mem[8]}, 32'h0001_FFF1);
        scan_en = 1'b0;

        // touch during WAIT protects idx 9; idx 10 still ages out
        clear_init();
        init_mem[9]  = {1'b1, 16'd0};
        init_mem[10] = {1'b1, 16'd0};
        timeout_cfg = 16'd100; cur_timestamp = 16'd100;
        do_reset();
        scan_en = 1'b1;
        wait_rd("t3_r9", 10'd9, 60);
        @(negedge clk);
        touch_valid = 1'b1; touch_idx = 10'd9;
        @(negedge clk);
        touch_valid = 1'b0; touch_idx = 10'd0;
        wait_rd("t3_r11", 10'd11, 20);
        check_eq("t3_wr_n", wr_n, 32'd1);
        check_eq("t3_wr_idx", {22'd0, wr_log[0]}, 32'd10);
        check_eq("t3_ev_n", ev_n, 32'd1);
        check_eq("t3_ev_info", {16'd0, ev_log[0]}, 32'd10);
        check_eq("t3_mem9", {15'd0, mem[9]}, 32'h0001_0000);
        scan_en = 1'b0;

        // backpressure: event on idx 3 held 20 cycles, scan stalled
        clear_init();
        init_mem[3] = {1'b1, 16'd0};
        timeout_cfg = 16'd100; cur_timestamp = 16'd100;
        agingInfo_ready = 1'b0;
        do_reset();
        scan_en = 1'b1;
        wait_ev("t4_ev_seen", 40);
        held = 0; rd_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (agingInfo_valid && (agingInfo == 16'd3)) held++;
            if (rdValid_agingTb) rd_bad++;
            @(negedge clk);
        end
        agingInfo_ready = 1'b1;
        wait_rd("t4_resume4", 10'd4, 5);
        check_eq("t4_held", held, 32'd20);
        check_eq("t4_rd_in_stall", rd_bad, 32'd0);
        check_eq("t4_ev_n", ev_n, 32'd1);
        check_eq("t4_ev_info", {16'd0, ev_log[0]}, 32'd3);
        check_eq("t4_wr_n", wr_n, 32'd1);
        scan_en = 1'b0;

        // reset while in EMIT
        clear_init();
        init_mem[2] = {1'b1, 16'd0};
        timeout_cfg = 16'd100; cur_timestamp = 16'd100;
        agingInfo_ready = 1'b0;
        do_reset();
        scan_en = 1'b1;
        wait_ev("t6_ev_seen", 30);
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_rdValid", {31'd0, rdValid_agingTb}, 32'd0);
        check_eq("t6_wrValid", {31'd0, wrValid_agingTb}, 32'd0);
        check_eq("t6_evValid", {31'd0, agingInfo_valid}, 32'd0);
        check_eq("t6_info", {16'd0, agingInfo}, 32'd0);
        check_eq("t6_idx", {22'd0, idx_agingTb}, 32'd0);
        check_eq("t6_done", {31'd0, sweep_done}, 32'd0);
`ifdef AGING_STATS_EN
        check_eq("t6_aged_cnt", aged_cnt, 32'd0);
`endif
        reset = 1'b1;
        agingInfo_ready = 1'b1;
        @(negedge clk);
        check_eq("t6_first_rd", {31'd0, rdValid_agingTb}, 32'd1);
        check_eq("t6_first_idx", {22'd0, idx_agingTb}, 32'd1);
        scan_en = 1'b0;

        // full sweep of a 3-bit-index table
        do_reset();
        s_scan_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_rd_n >= 8) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("t5_eight_reads", {31'd0, found}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("t5_rd%0d", i), {29'd0, s_rd_log[i]}, i + 1);
        end
        check_eq("t5_wrap_rd", {29'd0, s_rd_log[7]}, 32'd1);
        check_eq("t5_done_n", s_done_n, 32'd1);
        check_eq("t5_done_after", s_done_at, 32'd7);
        check_eq("t5_done_idx", {29'd0, s_done_idx}, 32'd7);
        s_scan_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
